// File: rtl/sync_fifo_adv.sv
// rtl/sync_fifo_adv.sv - single-clock FIFO with almost flags, error pulses and optional FWFT read
// Storage is never reset; pointers, count, flags and the registered read word are.
module sync_fifo_adv #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = 12,
  parameter int AEMPTY_TH  = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wen,
  input  logic                  ren,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  wfull,
  output logic                  rempty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_C  = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AFULL_C  = AFULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   AEMPTY_C = AEMPTY_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  wr_en, rd_en;

  // Full/empty come from the registered count, so a read at full never frees room for a same-cycle write.
  assign wfull  = (count_q == DEPTH_C);
  assign rempty = (count_q == '0);
  assign afull  = (count_q >= AFULL_C);
  assign aempty = (count_q <= AEMPTY_C);
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  assign wr_en = wen && !wfull;
  assign rd_en = ren && !rempty;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = wen && wfull;
    underflow_d = ren && rempty;
    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_en) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (wr_en && !rd_en) count_d = count_q + CNT_ONE;
    else if (rd_en && !wr_en) count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rdata = mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rdata_q;
      always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (rd_en) rdata_q <= mem_q[rd_ptr_q];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_adv.sv
// tb/tb_sync_fifo_adv.sv - scoreboard bench for sync_fifo_adv in standard and FWFT modes
module tb_sync_fifo_adv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wen, ren;
  logic [31:0] wdata;
  logic [31:0] rdata0, rdata1;
  logic        wfull0, rempty0, afull0, aempty0, ovf0, udf0;
  logic        wfull1, rempty1, afull1, aempty1, ovf1, udf1;
  logic [4:0]  count0, count1;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_rd0;
  logic        m_ovf, m_udf;

  sync_fifo_adv #(.FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .wdata(wdata), .rdata(rdata0),
    .wfull(wfull0), .rempty(rempty0), .afull(afull0), .aempty(aempty0),
    .count(count0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_adv #(.FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wen(wen), .ren(ren), .wdata(wdata), .rdata(rdata1),
    .wfull(wfull1), .rempty(rempty1), .afull(afull1), .aempty(aempty1),
    .count(count1), .overflow(ovf1), .underflow(udf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int cnt;
    cnt = m_q.size();
    chk("count0", 32'(count0), 32'(cnt));
    chk("wfull0", 32'(wfull0), 32'(cnt == 16));
    chk("rempty0", 32'(rempty0), 32'(cnt == 0));
    chk("afull0", 32'(afull0), 32'(cnt >= 12));
    chk("aempty0", 32'(aempty0), 32'(cnt <= 4));
    chk("overflow0", 32'(ovf0), 32'(m_ovf));
    chk("underflow0", 32'(udf0), 32'(m_udf));
    chk("rdata0_hold", rdata0, m_rd0);
    chk("count1", 32'(count1), 32'(cnt));
    chk("wfull1", 32'(wfull1), 32'(cnt == 16));
    chk("rempty1", 32'(rempty1), 32'(cnt == 0));
    chk("afull1", 32'(afull1), 32'(cnt >= 12));
    chk("aempty1", 32'(aempty1), 32'(cnt <= 4));
    chk("overflow1", 32'(ovf1), 32'(m_ovf));
    chk("underflow1", 32'(udf1), 32'(m_udf));
    if (cnt != 0) chk("rdata1_fwft", rdata1, m_q[0]);
  endtask

  task automatic step(input logic r_st, input logic w, input logic r, input logic [31:0] d);
    bit wa, ra;
    @(negedge clk);
    rst = r_st; wen = w; ren = r; wdata = d;
    @(posedge clk);
    if (r_st) begin
      m_q.delete();
      m_rd0 = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      wa = w && (m_q.size() != 16);
      ra = r && (m_q.size() != 0);
      m_ovf = w && (m_q.size() == 16);
      m_udf = r && (m_q.size() == 0);
      if (ra) begin
        m_rd0 = m_q.pop_front();
        exp_q.push_back(m_rd0);
      end
      if (wa) m_q.push_back(d);
    end
    #1 check_outputs();
  endtask

  // Registered-read monitor: a pop accepted at an edge must show the queued word just after it.
  initial begin
    bit fire;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #2 fire = ren && !rempty0 && !rst;
      @(posedge clk);
      #2;
      if (fire) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_scoreboard_underrun actual=pop required=none t=%0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("rd_scoreboard", rdata0, e);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; wdata = '0;
    m_rd0 = '0; m_ovf = 1'b0; m_udf = 1'b0;

    for (int i = 0; i < 3; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);

    for (int i = 0; i <= 16; i++) step(1'b0, 1'b1, 1'b0, 32'(i));
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, 1'b1, 32'h0);

    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0, 32'(100 + i));
    step(1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
    chk("full_rw_overflow", 32'(ovf0), 32'h1);
    for (int i = 0; i < 1000; i++)
      step(1'b0, 1'($urandom_range(0, 99) < (i < 500 ? 70 : 30)),
           1'($urandom_range(0, 99) < (i < 500 ? 40 : 70)), $urandom);
    while (m_q.size() != 0) step(1'b0, 1'b0, 1'b1, 32'h0);

    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'hA5A5_A5A5);
    chk("fwft_latency_rdata", rdata1, 32'hA5A5_A5A5);
    chk("fwft_latency_rempty", 32'(rempty1), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("fwft_hold_rdata", rdata1, 32'hA5A5_A5A5);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("fwft_pop_rempty", 32'(rempty1), 32'h1);

    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 32'(32'h7700 + i));
    chk("midop_count7", 32'(count0), 32'h7);
    step(1'b1, 1'b1, 1'b1, 32'hBAD0_BAD0);
    chk("midop_count0", 32'(count0), 32'h0);
    chk("midop_rempty", 32'(rempty0), 32'h1);
    step(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    chk("midop_fwft_new", rdata1, 32'h1234_5678);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("midop_read_new", rdata0, 32'h1234_5678);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
